// File: rtl/audio_meter_sched.sv
// -----------------------------------------------------------------------------
// audio_meter_sched
//
// Round-robin scheduler that shares one magnitude-averaging datapath between
// NUM_CH audio channels. Each accepted signed 8-bit sample contributes its
// absolute value to a per-channel running sum. After 2^WIN_LOG2 samples the
// window average is placed in a valid/ready output register. An 8-bit LED
// meter shows the one-hot MSB of the last average of the selected channel.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   ch_req     per-channel sample request (held with data until acked)
//   ch_data    8-bit signed samples, channel i at [8i+7:8i]
//   ch_ack     combinational one-hot grant; sample consumed at that edge
//   avg_valid  output register holds an unread average
//   avg_ready  consumer accepts on avg_valid && avg_ready
//   avg_data   window average, 0..128
//   avg_ch     channel index of avg_data
//   led_sel    channel shown on the LED meter (>= NUM_CH shows 0)
//   led        one-hot MSB of the selected channel's last average
// -----------------------------------------------------------------------------
module audio_meter_sched #(
    parameter int NUM_CH   = 4,
    parameter int WIN_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     ch_req,
    input  logic [8*NUM_CH-1:0]   ch_data,
    output logic [NUM_CH-1:0]     ch_ack,
    output logic                  avg_valid,
    input  logic                  avg_ready,
    output logic [7:0]            avg_data,
    output logic [2:0]            avg_ch,
    input  logic [2:0]            led_sel,
    output logic [7:0]            led
);

    localparam int                  SUM_W    = WIN_LOG2 + 8;
    localparam logic [3:0]          NUM_CH_L = 4'(NUM_CH);
    localparam logic [WIN_LOG2-1:0] CNT_LAST = {WIN_LOG2{1'b1}};

    // Absolute value of a two's-complement sample; -128 maps to 128.
    function automatic logic [8:0] magnitude(input logic [7:0] x);
        logic [8:0] m;
        if (x[7]) begin
            m = {1'b0, ~x} + 9'd1;
        end else begin
            m = {1'b0, x};
        end
        return m;
    endfunction

    // One-hot of the highest set bit; zero input gives zero.
    function automatic logic [7:0] msb_onehot(input logic [7:0] x);
        logic [7:0] r;
        r = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if (x[i]) begin
                r = 8'd1 << i;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Per-channel state is sized to 8 entries so a 3-bit index always fits;
    // entries at or above NUM_CH are never granted and stay at reset value.
    logic [SUM_W-1:0]    sum_r      [8];
    logic [WIN_LOG2-1:0] cnt_r      [8];
    logic [7:0]          last_avg_r [8];
    logic [2:0]          rr_r;
    logic                avg_valid_r;
    logic [7:0]          avg_data_r;
    logic [2:0]          avg_ch_r;
    logic [7:0]          led_r;

    logic [7:0]          data_s [8];
    logic [7:0]          elig_s;
    logic                out_busy_s;
    logic                grant_s;
    logic [2:0]          grant_idx_s;
    logic                close_s;
    logic [8:0]          mag_s;
    logic [SUM_W-1:0]    total_s;
    logic [7:0]          avg_s;
    logic [2:0]          rr_next_s;

    // Unpack samples and decide which channels may be granted this cycle.
    // A channel whose next sample closes its window must wait while an
    // unread result occupies the output register.
    always_comb begin
        out_busy_s = avg_valid_r & ~avg_ready;
        for (int i = 0; i < 8; i++) begin
            data_s[i] = 8'd0;
            elig_s[i] = 1'b0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            data_s[i] = ch_data[8*i +: 8];
            elig_s[i] = ch_req[i] & ~reset & ~(out_busy_s & (cnt_r[i] == CNT_LAST));
        end
    end

    // Round-robin pick: scan from lowest to highest priority so the
    // highest-priority eligible channel is the last one written.
    always_comb begin
        logic [3:0] idx4;
        idx4        = 4'd0;
        grant_s     = 1'b0;
        grant_idx_s = 3'd0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx4 = {1'b0, rr_r} + 4'(k);
            if (idx4 >= NUM_CH_L) begin
                idx4 = idx4 - NUM_CH_L;
            end else begin
                idx4 = idx4;
            end
            if (elig_s[idx4[2:0]]) begin
                grant_s     = 1'b1;
                grant_idx_s = idx4[2:0];
            end else begin
                grant_s     = grant_s;
            end
        end
    end

    // One-hot acknowledge towards the requesters.
    always_comb begin
        ch_ack = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            ch_ack[i] = grant_s & (grant_idx_s == 3'(i));
        end
    end

    // Shared datapath: magnitude, running total, window average, next pointer.
    always_comb begin
        close_s = grant_s & (cnt_r[grant_idx_s] == CNT_LAST);
        mag_s   = magnitude(data_s[grant_idx_s]);
        total_s = sum_r[grant_idx_s] + SUM_W'(mag_s);
        avg_s   = total_s[SUM_W-1:WIN_LOG2];
        if (({1'b0, grant_idx_s} + 4'd1) == NUM_CH_L) begin
            rr_next_s = 3'd0;
        end else begin
            rr_next_s = grant_idx_s + 3'd1;
        end
    end

    // Accumulator, pointer and output-register update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                sum_r[i]      <= {SUM_W{1'b0}};
                cnt_r[i]      <= {WIN_LOG2{1'b0}};
                last_avg_r[i] <= 8'd0;
            end
            rr_r        <= 3'd0;
            avg_valid_r <= 1'b0;
            avg_data_r  <= 8'd0;
            avg_ch_r    <= 3'd0;
        end else begin
            if (grant_s) begin
                rr_r <= rr_next_s;
                if (close_s) begin
                    sum_r[grant_idx_s]      <= {SUM_W{1'b0}};
                    cnt_r[grant_idx_s]      <= {WIN_LOG2{1'b0}};
                    last_avg_r[grant_idx_s] <= avg_s;
                    avg_data_r              <= avg_s;
                    avg_ch_r                <= grant_idx_s;
                    avg_valid_r             <= 1'b1;
                end else begin
                    sum_r[grant_idx_s] <= total_s;
                    cnt_r[grant_idx_s] <= cnt_r[grant_idx_s] + WIN_LOG2'(1);
                end
            end else begin
                rr_r <= rr_r;
            end
            // A handshake frees the register unless a new result lands on it.
            if (avg_valid_r && avg_ready && !close_s) begin
                avg_valid_r <= 1'b0;
            end else begin
                avg_valid_r <= avg_valid_r | close_s;
            end
        end
    end

    // LED meter for the selected channel's most recent average.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_r <= 8'd0;
        end else if ({1'b0, led_sel} < NUM_CH_L) begin
            led_r <= msb_onehot(last_avg_r[led_sel]);
        end else begin
            led_r <= 8'd0;
        end
    end

    assign avg_valid = avg_valid_r;
    assign avg_data  = avg_data_r;
    assign avg_ch    = avg_ch_r;
    assign led       = led_r;

endmodule

// File: tb/tb_audio_meter_sched.sv
// Testbench for audio_meter_sched (NUM_CH=4, WIN_LOG2=2). A behavioural model
// keeps each channel's open window as a queue of magnitudes and predicts the
// grant, output register and LED every cycle.
module tb_audio_meter_sched;

    localparam int NCH = 4;
    localparam int WL  = 2;
    localparam int WIN = 1 << WL;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    ch_req;
    logic [8*NCH-1:0]  ch_data;
    logic [NCH-1:0]    ch_ack;
    logic              avg_valid;
    logic              avg_ready;
    logic [7:0]        avg_data;
    logic [2:0]        avg_ch;
    logic [2:0]        led_sel;
    logic [7:0]        led;

    always #5 clk = ~clk;

    audio_meter_sched #(.NUM_CH(NCH), .WIN_LOG2(WL)) dut (
        .clk(clk), .reset(reset), .ch_req(ch_req), .ch_data(ch_data),
        .ch_ack(ch_ack), .avg_valid(avg_valid), .avg_ready(avg_ready),
        .avg_data(avg_data), .avg_ch(avg_ch), .led_sel(led_sel), .led(led)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int       win_q [NCH][$];
    int       rr_m;
    bit       out_v;
    int       out_d;
    int       out_c;
    int       last_m [NCH];
    int       led_m;
    int       last_g;
    logic [NCH-1:0] ack_seen;
    bit       pend [NCH];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int abs_sample(input logic [7:0] x);
        byte s;
        s = byte'(x);
        return (s < 0) ? -int'(s) : int'(s);
    endfunction

    function automatic int led_model(input int v);
        int b;
        if (v == 0) return 0;
        b = 0;
        while ((1 << (b + 1)) <= v) b++;
        return 1 << b;
    endfunction

    // Channel the scheduler should grant now, or -1.
    function automatic int model_grant();
        int c;
        bit blocked;
        if (reset) return -1;
        for (int k = 0; k < NCH; k++) begin
            c = (rr_m + k) % NCH;
            blocked = (win_q[c].size() == WIN - 1) && out_v && !avg_ready;
            if (ch_req[c] && !blocked) return c;
        end
        return -1;
    endfunction

    task automatic model_update(input int g);
        int mag, tot;
        bit hs, close;
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                win_q[c].delete();
                last_m[c] = 0;
            end
            rr_m = 0; out_v = 0; out_d = 0; out_c = 0; led_m = 0;
            return;
        end
        led_m = (int'(led_sel) < NCH) ? led_model(last_m[led_sel]) : 0;
        hs    = out_v && avg_ready;
        close = 0;
        if (g >= 0) begin
            mag = abs_sample(ch_data[8*g +: 8]);
            if (win_q[g].size() == WIN - 1) begin
                tot = mag;
                for (int j = 0; j < win_q[g].size(); j++) tot += win_q[g][j];
                out_d = tot / WIN;
                out_c = g;
                out_v = 1;
                last_m[g] = out_d;
                win_q[g].delete();
                close = 1;
            end else begin
                win_q[g].push_back(mag);
            end
            rr_m = (g + 1) % NCH;
        end
        if (hs && !close) out_v = 0;
    endtask

    // One clock: inputs already applied at the falling edge.
    task automatic step();
        int g;
        logic [NCH-1:0] exp_ack;
        #1;
        g = model_grant();
        exp_ack = (g >= 0) ? NCH'(1 << g) : '0;
        ack_seen = ch_ack;
        check_val("ack", 32'(ch_ack), 32'(exp_ack));
        @(posedge clk);
        model_update(g);
        last_g = g;
        #1;
        check_val("avg_valid", 32'(avg_valid), 32'(out_v));
        check_val("avg_data", 32'(avg_data), 32'(out_d));
        check_val("avg_ch", 32'(avg_ch), 32'(out_c));
        check_val("led", 32'(led), 32'(led_m));
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic send(input int c, input logic [7:0] v);
        ch_req = '0;
        ch_req[c] = 1'b1;
        ch_data[8*c +: 8] = v;
        step();
    endtask

    task automatic idle(input int n);
        ch_req = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1'b1; ch_req = '0; ch_data = '0; avg_ready = 1'b1; led_sel = 3'd0;
        rr_m = 0; out_v = 0; out_d = 0; out_c = 0; led_m = 0; last_g = -1;
        for (int c = 0; c < NCH; c++) begin last_m[c] = 0; pend[c] = 0; end
        @(negedge clk);
        ch_req = '1;
        step();
        step();
        reset = 1'b0;
        ch_req = '0;

        // single channel, -4 four times -> average 4
        for (int i = 0; i < WIN; i++) send(0, 8'hFC);
        check_val("tp_neg4_avg", 32'(avg_data), 32'd4);
        check_val("tp_neg4_valid", 32'(avg_valid), 32'd1);
        idle(1);

        // all channels requesting: strict 0,1,2,3 rotation
        do_reset();
        ch_req = '1;
        ch_data = 32'h11_F0_80_7F;
        for (int k = 0; k < 8; k++) begin
            step();
            check_val("rr_order", 32'(ack_seen), 32'(1 << (k % NCH)));
        end
        idle(1);

        // full-scale negative on channel 2, LED shows MSB
        do_reset();
        led_sel = 3'd2;
        for (int i = 0; i < WIN; i++) send(2, 8'h80);
        check_val("tp_full_avg", 32'(avg_data), 32'd128);
        idle(1);
        check_val("tp_full_led", 32'(led), 32'h80);

        // back-pressure blocks only a window-closing sample
        do_reset();
        avg_ready = 1'b0;
        for (int i = 0; i < WIN; i++) send(0, 8'hFC);
        for (int i = 0; i < WIN - 1; i++) send(1, 8'h10);
        ch_req = 4'b1010;
        ch_data[8*3 +: 8] = 8'h20;
        for (int i = 0; i < 2; i++) begin
            step();
            check_val("blk_ack", 32'(ack_seen), 32'b1000);
        end
        avg_ready = 1'b1;
        step();
        check_val("unblk_ack", 32'(ack_seen), 32'b0010);
        check_val("unblk_valid", 32'(avg_valid), 32'd1);
        check_val("unblk_ch", 32'(avg_ch), 32'd1);
        check_val("unblk_data", 32'(avg_data), 32'd16);
        idle(2);

        // reset in the middle of a window discards the partial sum
        do_reset();
        for (int i = 0; i < WIN - 1; i++) send(0, 8'h40);
        ch_req = 4'b0001;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < WIN; i++) send(0, 8'h08);
        check_val("rst_avg", 32'(avg_data), 32'd8);
        idle(1);

        // mixed samples
        do_reset();
        led_sel = 3'd0;
        send(0, 8'h7F); send(0, 8'h81); send(0, 8'h00); send(0, 8'h02);
        check_val("mix_avg", 32'(avg_data), 32'd64);
        idle(1);
        check_val("mix_led", 32'(led), 32'h40);

        // randomized traffic with held requests
        do_reset();
        for (int n = 0; n < 600; n++) begin
            avg_ready = ($urandom_range(3) != 0);
            led_sel   = 3'($urandom_range(7));
            reset     = ($urandom_range(149) == 0);
            for (int c = 0; c < NCH; c++) begin
                if (!pend[c] && $urandom_range(9) < 6) begin
                    pend[c] = 1;
                    ch_data[8*c +: 8] = 8'($urandom);
                end
                ch_req[c] = pend[c];
            end
            step();
            if (last_g >= 0) pend[last_g] = 0;
        end
        reset = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
